// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter sharing the LEGv8 register-file write port between ALU and load writeback.
// Optional power-up sweep of X0..X30 to zero is enabled by defining REGFILE_ARB_INIT_EN.
module regfile_wport_arbiter #(
  parameter int N         = 64,
  parameter int INIT_LAST = 30
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [4:0]   a_addr,
  input  logic [N-1:0] a_data,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [4:0]   b_addr,
  input  logic [N-1:0] b_data,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3,
  output logic         init_done
);

  localparam logic [4:0] XZR = 5'd31;

  logic         in_run;
  logic         prio_b;
  logic         nxt_we;
  logic [4:0]   nxt_wa;
  logic [N-1:0] nxt_wd;
  logic         nxt_prio_b;

  // prio_b set means B wins a tie; A wins otherwise
  assign a_ready = in_run & a_valid & (~b_valid | ~prio_b);
  assign b_ready = in_run & b_valid & (~a_valid | prio_b);

  // Next write-port contents in RUN; XZR writes complete the handshake but never assert we3
  always_comb begin
    nxt_we     = 1'b0;
    nxt_wa     = wa3;
    nxt_wd     = wd3;
    nxt_prio_b = prio_b;
    if (a_ready) begin
      nxt_we     = (a_addr != XZR);
      nxt_wa     = a_addr;
      nxt_wd     = a_data;
      nxt_prio_b = 1'b1;
    end else if (b_ready) begin
      nxt_we     = (b_addr != XZR);
      nxt_wa     = b_addr;
      nxt_wd     = b_data;
      nxt_prio_b = 1'b0;
    end
  end

`ifdef REGFILE_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [4:0] LAST = 5'(INIT_LAST);

  state_t     state;
  logic [4:0] cnt;

  assign in_run    = (state == ST_RUN);
  assign init_done = in_run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_INIT;
      cnt    <= '0;
      we3    <= 1'b0;
      wa3    <= '0;
      wd3    <= '0;
      prio_b <= 1'b0;
    end else if (state == ST_INIT) begin
      we3 <= 1'b1;
      wa3 <= cnt;
      wd3 <= '0;
      cnt <= cnt + 5'd1;
      if (cnt == LAST)
        state <= ST_RUN;
    end else begin
      we3    <= nxt_we;
      wa3    <= nxt_wa;
      wd3    <= nxt_wd;
      prio_b <= nxt_prio_b;
    end
  end
`else
  assign in_run    = 1'b1;
  assign init_done = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we3    <= 1'b0;
      wa3    <= '0;
      wd3    <= '0;
      prio_b <= 1'b0;
    end else begin
      we3    <= nxt_we;
      wa3    <= nxt_wa;
      wd3    <= nxt_wd;
      prio_b <= nxt_prio_b;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed self-checking bench for regfile_wport_arbiter, with a behavioural register file on the write port.
// Covers both builds; the sweep tests are active when REGFILE_ARB_INIT_EN is defined.
module tb_regfile_wport_arbiter;

  localparam int N = 64;
  localparam logic [N-1:0] RF_INIT = 64'hA5A5_A5A5_A5A5_A5A5;
`ifdef REGFILE_ARB_INIT_EN
  localparam logic INIT_RST = 1'b0;
`else
  localparam logic INIT_RST = 1'b1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         aValid, bValid;
  logic [4:0]   aAddr, bAddr;
  logic [N-1:0] aData, bData;
  logic         aReady, bReady;
  logic         we3;
  logic [4:0]   wa3;
  logic [N-1:0] wd3;
  logic         initDone;

  int checkCount = 0;
  int passCount  = 0;

  logic [N-1:0] rfMem [32] = '{default: RF_INIT};

  regfile_wport_arbiter #(.N(N), .INIT_LAST(30)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (aValid),
    .a_ready   (aReady),
    .a_addr    (aAddr),
    .a_data    (aData),
    .b_valid   (bValid),
    .b_ready   (bReady),
    .b_addr    (bAddr),
    .b_data    (bData),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .init_done (initDone)
  );

  always #5 clk = ~clk;

  // Register file model: captures whatever the arbiter presents on the edge after it is registered
  always @(posedge clk) begin
    if (we3)
      rfMem[wa3] <= wd3;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [N-1:0] ad,
                               input logic bv, input logic [4:0] ba, input logic [N-1:0] bd);
    aValid = av; aAddr = aa; aData = ad;
    bValid = bv; bAddr = ba; bData = bd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

`ifdef REGFILE_ARB_INIT_EN
  // Starts just after reset release; requesters stay valid to prove they are held off
  task automatic runSweep(input string tag);
    applyStimulus(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
    for (int i = 0; i < 31; i++) begin
      #1;
      checkOutput({tag, "_aready"}, aReady, 1'b0);
      checkOutput({tag, "_bready"}, bReady, 1'b0);
      checkOutput({tag, "_done_low"}, initDone, 1'b0);
      tick;
      checkOutput({tag, "_we3"}, we3, 1'b1);
      checkOutput({tag, "_wa3"}, wa3, 64'(i));
      checkOutput({tag, "_wd3"}, wd3, 64'h0);
    end
    checkOutput({tag, "_done_high"}, initDone, 1'b1);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask
`endif

  initial begin
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    reset = 1'b0;
    tick;
    tick;
    checkOutput("rst_we3", we3, 1'b0);
    checkOutput("rst_wa3", wa3, 64'h0);
    checkOutput("rst_wd3", wd3, 64'h0);
    checkOutput("rst_init_done", initDone, INIT_RST);
    checkOutput("rst_aready", aReady, 1'b0);
    reset = 1'b1;

`ifdef REGFILE_ARB_INIT_EN
    runSweep("sweep");
    tick;
    for (int r = 0; r < 31; r++)
      checkOutput("sweep_rf_zero", rfMem[r], 64'h0);
`endif

    // Single A write
    applyStimulus(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, '0);
    #1;
    checkOutput("single_aready", aReady, 1'b1);
    checkOutput("single_bready", bReady, 1'b0);
    tick;
    checkOutput("single_we3", we3, 1'b1);
    checkOutput("single_wa3", wa3, 64'd5);
    checkOutput("single_wd3", wd3, 64'hDEAD_BEEF);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    tick;
    checkOutput("single_rf5", rfMem[5], 64'hDEAD_BEEF);
    checkOutput("idle_we3", we3, 1'b0);
    checkOutput("idle_wa3_hold", wa3, 64'd5);

    // XZR write from B: handshake completes, write dropped; priority returns to A
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd31, 64'h1234);
    #1;
    checkOutput("xzr_bready", bReady, 1'b1);
    tick;
    checkOutput("xzr_we3", we3, 1'b0);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    tick;
    checkOutput("xzr_rf31", rfMem[31], RF_INIT);

    // Sustained contention alternates A, B, A, B
    applyStimulus(1'b1, 5'd1, 64'd11, 1'b1, 5'd2, 64'd22);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("cont_aready", aReady, (k % 2) == 0);
      checkOutput("cont_bready", bReady, (k % 2) == 1);
      tick;
      checkOutput("cont_we3", we3, 1'b1);
      checkOutput("cont_wa3", wa3, ((k % 2) == 0) ? 64'd1 : 64'd2);
      checkOutput("cont_wd3", wd3, ((k % 2) == 0) ? 64'd11 : 64'd22);
    end
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // A-only write hands priority to B, then A is backpressured while holding its request
    applyStimulus(1'b1, 5'd7, 64'd77, 1'b0, 5'd0, '0);
    tick;
    checkOutput("prio_setup_wa3", wa3, 64'd7);
    applyStimulus(1'b1, 5'd9, 64'd99, 1'b1, 5'd10, 64'd100);
    #1;
    checkOutput("bp_aready", aReady, 1'b0);
    checkOutput("bp_bready", bReady, 1'b1);
    tick;
    checkOutput("bp_b_wa3", wa3, 64'd10);
    checkOutput("bp_b_wd3", wd3, 64'd100);
    applyStimulus(1'b1, 5'd9, 64'd99, 1'b0, 5'd0, '0);
    #1;
    checkOutput("bp_aready_late", aReady, 1'b1);
    tick;
    checkOutput("bp_a_we3", we3, 1'b1);
    checkOutput("bp_a_wa3", wa3, 64'd9);
    checkOutput("bp_a_wd3", wd3, 64'd99);

    // Idle cycles keep wa3/wd3 and do not move priority (still B)
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    tick;
    tick;
    checkOutput("hold_we3", we3, 1'b0);
    checkOutput("hold_wa3", wa3, 64'd9);
    checkOutput("hold_wd3", wd3, 64'd99);
    applyStimulus(1'b1, 5'd20, 64'd200, 1'b1, 5'd21, 64'd210);
    #1;
    checkOutput("hold_prio_aready", aReady, 1'b0);
    checkOutput("hold_prio_bready", bReady, 1'b1);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // Reset mid-RUN clears the pending write immediately
    applyStimulus(1'b1, 5'd6, 64'd66, 1'b0, 5'd0, '0);
    tick;
    checkOutput("midrun_we3_before", we3, 1'b1);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    reset = 1'b0;
    #1;
    checkOutput("midrun_we3_async", we3, 1'b0);
    checkOutput("midrun_wa3_async", wa3, 64'h0);
    checkOutput("midrun_wd3_async", wd3, 64'h0);
    tick;
    reset = 1'b1;
`ifdef REGFILE_ARB_INIT_EN
    runSweep("resweep");
`endif
    applyStimulus(1'b1, 5'd12, 64'd120, 1'b1, 5'd13, 64'd130);
    #1;
    checkOutput("midrun_prio_aready", aReady, 1'b1);
    checkOutput("midrun_prio_bready", bReady, 1'b0);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

`ifdef REGFILE_ARB_INIT_EN
    // Reset mid-sweep at wa3=12 restarts the full 31-cycle sweep
    reset = 1'b0;
    tick;
    reset = 1'b1;
    for (int i = 0; i < 13; i++)
      tick;
    checkOutput("midsweep_wa3", wa3, 64'd12);
    reset = 1'b0;
    #1;
    checkOutput("midsweep_we3_async", we3, 1'b0);
    checkOutput("midsweep_done", initDone, 1'b0);
    tick;
    reset = 1'b1;
    runSweep("restart");
`endif

    tick;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
